// File: rtl/tick_counter20.sv
// tick_counter20: up/down 0..MAXCOUNT counter stepped by mclk rising edges, with BCD and 7-segment outputs
//   i_clock     system clock, all state on its rising edge
//   i_reset     synchronous active-high reset
//   i_mclk      slow square wave synchronous to i_clock; rising edges step the count
//   i_en        count enable (edges seen while low are dropped)
//   i_up        direction, 1 = increment, 0 = decrement
//   i_clr       synchronous clear of count, overrides a step
//   o_count     binary count 0..MAXCOUNT
//   o_tens      BCD tens digit of o_count
//   o_ones      BCD ones digit of o_count
//   o_seg_tens  active-low {g,f,e,d,c,b,a} for o_tens
//   o_seg_ones  active-low {g,f,e,d,c,b,a} for o_ones
//   o_tick      one-cycle pulse after every detected mclk rising edge
//   o_wrap      one-cycle pulse after the count wraps in either direction
module tick_counter20 #(
  parameter int MAXCOUNT = 19
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_mclk,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_clr,
  output logic [6:0] o_count,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [6:0] o_seg_tens,
  output logic [6:0] o_seg_ones,
  output logic       o_tick,
  output logic       o_wrap
);
  localparam logic [6:0] MAX = 7'(MAXCOUNT);
  logic       r_mclk_d;
  logic [6:0] r_count;
  logic       r_tick;
  logic       r_wrap;
  logic       w_edge;
  logic       w_step;
  logic       w_top;
  // r_mclk_d resets high so an mclk already high at reset release is not an edge
  assign w_edge = i_mclk & ~r_mclk_d;
  assign w_step = w_edge & i_en & ~i_clr;
  assign w_top  = i_up ? (r_count == MAX) : (r_count == 7'd0);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mclk_d <= 1'b1;
      r_count  <= 7'd0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_mclk_d <= i_mclk;
      r_tick   <= w_edge;
      r_wrap   <= w_step & w_top;
      r_count  <= i_clr ? 7'd0 :
                  !w_step ? r_count :
                  w_top ? (i_up ? 7'd0 : MAX) :
                  i_up ? r_count + 7'd1 : r_count - 7'd1;
    end
  end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  assign o_count    = r_count;
  assign o_tens     = 4'(r_count / 7'd10);
  assign o_ones     = 4'(r_count % 7'd10);
  assign o_seg_tens = seg7(o_tens);
  assign o_seg_ones = seg7(o_ones);
  assign o_tick     = r_tick;
  assign o_wrap     = r_wrap;
endmodule

// File: tb/tb_tick_counter20.sv
// tb_tick_counter20: randomized and directed self-checking bench for tick_counter20
module tb_tick_counter20;
  localparam int MAX = 19;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mclk = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic [6:0] count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       tick;
  logic       wrap;
  int         errors = 0;
  int         checks = 0;
  int         exp_count = 0;
  bit         exp_tick = 0;
  bit         exp_wrap = 0;
  bit         prev_m = 1;
  int         obs_ticks = 0;
  int         obs_wraps = 0;
  logic [6:0] seg_tab [10];

  tick_counter20 #(.MAXCOUNT(MAX)) dut (
    .i_clock(clk), .i_reset(reset), .i_mclk(mclk), .i_en(en), .i_up(up), .i_clr(clr),
    .o_count(count), .o_tens(tens), .o_ones(ones), .o_seg_tens(seg_tens),
    .o_seg_ones(seg_ones), .o_tick(tick), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  // advances one clock and applies the counter rules to the reference model
  task automatic clk_step();
    bit e;
    e = mclk && !prev_m;
    @(posedge clk);
    if (reset) begin
      exp_count = 0;
      exp_tick  = 0;
      exp_wrap  = 0;
      prev_m    = 1;
    end else begin
      exp_tick = e;
      exp_wrap = 0;
      if (clr) exp_count = 0;
      else if (e && en) begin
        if (up) begin
          if (exp_count == MAX) begin exp_count = 0; exp_wrap = 1; end
          else exp_count = exp_count + 1;
        end else begin
          if (exp_count == 0) begin exp_count = MAX; exp_wrap = 1; end
          else exp_count = exp_count - 1;
        end
      end
      prev_m = mclk;
    end
    #1;
    obs_ticks += int'(tick);
    obs_wraps += int'(wrap);
  endtask

  task automatic edge_pulse(input int hi, input int lo);
    mclk = 1'b1;
    repeat (hi) clk_step();
    mclk = 1'b0;
    repeat (lo) clk_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mclk = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
    do_reset();
    checks++;
    if (count !== 7'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
    end
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || seg_tens !== 7'b1000000 || seg_ones !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_digits: tens=%0d ones=%0d seg_tens=%b seg_ones=%b, required 0 0 1000000 1000000",
               tens, ones, seg_tens, seg_ones);
    end
    clk_step();
  endtask

  task automatic test_count_up();
    bit bad = 0;
    obs_ticks = 0; obs_wraps = 0;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      edge_pulse(2, 2);
      if (int'(count) != i % 20) bad = 1;
    end
    checks++;
    if (bad || count !== 7'd0) begin
      errors++;
      $display("FAIL up_sequence: final count=%0d, required 1..19 then 0 ending at 0", count);
    end
    checks++;
    if (obs_ticks != 20 || obs_wraps != 1) begin
      errors++;
      $display("FAIL up_pulses: ticks=%0d wraps=%0d, required 20 and 1", obs_ticks, obs_wraps);
    end
  endtask

  task automatic test_down_wrap();
    obs_wraps = 0;
    up = 1'b0;
    edge_pulse(1, 2);
    checks++;
    if (count !== 7'd19 || tens !== 4'd1 || ones !== 4'd9) begin
      errors++;
      $display("FAIL down_wrap_count: count=%0d tens=%0d ones=%0d, required 19 1 9", count, tens, ones);
    end
    checks++;
    if (seg_tens !== 7'b1111001 || seg_ones !== 7'b0010000 || obs_wraps != 1) begin
      errors++;
      $display("FAIL down_wrap_seg: seg_tens=%b seg_ones=%b wraps=%0d, required 1111001 0010000 1",
               seg_tens, seg_ones, obs_wraps);
    end
  endtask

  task automatic test_hold_high();
    int start;
    start = int'(count);
    obs_ticks = 0;
    up = 1'b1; en = 1'b1;
    edge_pulse(1000, 3);
    checks++;
    if (int'(count) != (start + 1) % (MAX + 1) || obs_ticks != 1) begin
      errors++;
      $display("FAIL hold_high: count=%0d ticks=%0d, required %0d and 1", count, obs_ticks, (start + 1) % (MAX + 1));
    end
    edge_pulse(0, 50);
    checks++;
    if (int'(count) != (start + 1) % (MAX + 1) || obs_ticks != 1) begin
      errors++;
      $display("FAIL hold_low: count=%0d ticks=%0d, required unchanged", count, obs_ticks);
    end
  endtask

  task automatic test_enable();
    clr = 1'b1; clk_step(); clr = 1'b0;
    up = 1'b1; en = 1'b1;
    repeat (5) edge_pulse(1, 1);
    checks++;
    if (count !== 7'd5) begin
      errors++;
      $display("FAIL enable_setup: count=%0d, required 5", count);
    end
    obs_ticks = 0;
    en = 1'b0;
    repeat (3) edge_pulse(2, 2);
    en = 1'b1;
    edge_pulse(2, 2);
    checks++;
    if (count !== 7'd6 || obs_ticks != 4) begin
      errors++;
      $display("FAIL enable_gate: count=%0d ticks=%0d, required 6 and 4", count, obs_ticks);
    end
  endtask

  task automatic test_clr();
    clr = 1'b1; clk_step(); clr = 1'b0;
    up = 1'b0; en = 1'b1;
    edge_pulse(1, 2);
    checks++;
    if (count !== 7'd19) begin
      errors++;
      $display("FAIL clr_setup: count=%0d, required 19", count);
    end
    obs_ticks = 0; obs_wraps = 0;
    up = 1'b1; mclk = 1'b1; clr = 1'b1;
    clk_step();
    clr = 1'b0;
    checks++;
    if (count !== 7'd0 || wrap !== 1'b0 || tick !== 1'b1) begin
      errors++;
      $display("FAIL clr_override: count=%0d wrap=%b tick=%b, required 0 0 1", count, wrap, tick);
    end
    edge_pulse(0, 3);
    checks++;
    if (count !== 7'd0 || obs_wraps != 0 || obs_ticks != 1) begin
      errors++;
      $display("FAIL clr_after: count=%0d wraps=%0d ticks=%0d, required 0 0 1", count, obs_wraps, obs_ticks);
    end
  endtask

  task automatic test_reset_release();
    mclk = 1'b1; en = 1'b1; up = 1'b1;
    do_reset();
    obs_ticks = 0;
    repeat (6) clk_step();
    checks++;
    if (count !== 7'd0 || obs_ticks != 0) begin
      errors++;
      $display("FAIL release_high: count=%0d ticks=%0d, required 0 0", count, obs_ticks);
    end
    mclk = 1'b0; clk_step();
    mclk = 1'b1; clk_step();
    checks++;
    if (count !== 7'd1) begin
      errors++;
      $display("FAIL release_first_edge: count=%0d, required 1", count);
    end
    mclk = 1'b0; clk_step();
    repeat (11) edge_pulse(1, 1);
    checks++;
    if (count !== 7'd12) begin
      errors++;
      $display("FAIL reset_mid_setup: count=%0d, required 12", count);
    end
    mclk = 1'b1; reset = 1'b1; clr = 1'b1;
    clk_step();
    reset = 1'b0; clr = 1'b0;
    checks++;
    if (count !== 7'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d tick=%b wrap=%b, required 0 0 0", count, tick, wrap);
    end
    mclk = 1'b0; clk_step();
  endtask

  task automatic test_random();
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2, 0) == 0) mclk = ~mclk;
      en    = ($urandom_range(3, 0) != 0);
      up    = $urandom_range(1, 0) != 0;
      clr   = ($urandom_range(24, 0) == 0);
      reset = ($urandom_range(150, 0) == 0);
      clk_step();
      if (int'(count) != exp_count || tick !== exp_tick || wrap !== exp_wrap ||
          int'(tens) != exp_count / 10 || int'(ones) != exp_count % 10 ||
          seg_tens !== seg_tab[exp_count / 10] || seg_ones !== seg_tab[exp_count % 10]) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = i;
          $display("FAIL random_cycle%0d: count=%0d tick=%b wrap=%b seg=%b/%b, required %0d %b %b %b/%b",
                   i, count, tick, wrap, seg_tens, seg_ones, exp_count, exp_tick, exp_wrap,
                   seg_tab[exp_count / 10], seg_tab[exp_count % 10]);
        end
      end
    end
    reset = 1'b0; clr = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_model: %0d mismatching cycles, required 0", bad);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_hold_high();
    test_enable();
    test_clr();
    test_reset_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_counter20.md
TICK_COUNTER20 -- requirements
Module: tick_counter20

Interface
REQ-001 Parameter MAXCOUNT, default 19: terminal count value; legal range 1..99.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 mclk  input  1  slow square wave from the clock generator, synchronous to clock; only its rising edges advance the counter.
REQ-005 en  input  1  count enable; 1 = mclk rising edges advance count, 0 = hold.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 clr  input  1  synchronous clear of count to 0.
REQ-008 count  output  7  current count, binary, 0..MAXCOUNT.
REQ-009 tens  output  4  BCD tens digit of count.
REQ-010 ones  output  4  BCD ones digit of count.
REQ-011 seg_tens  output  7  active-low segments {g,f,e,d,c,b,a} for tens.
REQ-012 seg_ones  output  7  active-low segments {g,f,e,d,c,b,a} for ones.
REQ-013 tick  output  1  one-clock pulse, one cycle after each detected mclk rising edge, independent of en.
REQ-014 wrap  output  1  one-clock pulse, registered, on the cycle after count wraps in either direction.

Function
REQ-015 The block SHALL register mclk into mclk_d every clock; edge = mclk AND NOT mclk_d.
REQ-016 A step SHALL occur on the clock edge where edge=1, en=1, clr=0: count changes one clock after mclk is first sampled high.
REQ-017 Up step: count SHALL go count+1; at MAXCOUNT it SHALL go to 0 and assert wrap.
REQ-018 Down step: count SHALL go count-1; at 0 it SHALL go to MAXCOUNT and assert wrap.
REQ-019 An edge seen while en=0 SHALL be discarded, not deferred; mclk_d still updates.
REQ-020 clr=1 SHALL load count=0 on that edge, overriding any step; no wrap pulse; mclk_d and tick still update normally.
REQ-021 Priority SHALL be reset > clr > step > hold.
REQ-022 A change of up between edges SHALL affect only the next step; no step occurs without an edge.
REQ-023 tens = count/10 and ones = count mod 10, combinational from count, always consistent with count in the same cycle.
REQ-024 Segment outputs SHALL decode 0..9 to standard active-low patterns (0 -> 1000000, 1 -> 1111001, 8 -> 0000000); codes 10..15 SHALL drive 1111111 (blank).
REQ-025 tick and wrap SHALL be exactly one clock wide per event and never asserted in consecutive cycles from a single mclk high period.
REQ-026 mclk held high for many clocks SHALL produce exactly one step; mclk held low SHALL produce none.

Reset
REQ-027 On reset: count=0, wrap=0, tick=0, mclk_d=1, giving tens=0, ones=0, seg_tens=seg_ones=1000000.
REQ-028 mclk_d resetting to 1 SHALL guarantee that mclk already high at reset release produces no step until mclk has gone low then high again.
REQ-029 Reset asserted mid-count SHALL override clr, en and any simultaneous edge on that clock.

Verification
REQ-030 Reset, en=1, up=1, 20 mclk rising edges -> count 1..19 then 0, one wrap pulse at the 19->0 transition, 20 tick pulses.
REQ-031 count=0, up=0, one edge -> count=19, tens=1, ones=9, seg_tens=1111001, seg_ones=0010000, wrap pulses once.
REQ-032 mclk held high 1000 clocks then low, en=1 -> exactly one step, one tick pulse.
REQ-033 en=0 during 3 edges, then en=1 for 1 edge starting at count=5 -> count=6, tick pulsed 4 times.
REQ-034 count=19, clr=1 coincident with an up edge -> count=0, wrap stays 0, tick still pulses.
REQ-035 Release reset with mclk=1 -> count stays 0 until mclk falls and rises; reset asserted at count=12 with edge present -> count=0 next clock.
